// File: rtl/rx_watchdog_multi.sv
`timescale 1ns/1ps
// rx_watchdog_multi
// Multi-cause receiver watchdog. It watches the I/Q sign balance (DC-stuck
// input), the decoded packet length, the preamble-to-header latency and the
// demodulation duration. When any enabled check trips, it issues a
// fixed-length receiver_rst pulse, records the cause one-hot and bumps a
// saturating per-cause event counter.
module rx_watchdog_multi #(
  parameter int IQ_DATA_WIDTH = 16,
  parameter int LOG2_DC_WIN   = 5,
  parameter int LEN_WIDTH     = 16,
  parameter int TIMER_WIDTH   = 20,
  parameter int RST_PULSE_LEN = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     enable,
  input  logic [IQ_DATA_WIDTH-1:0] i_data,
  input  logic [IQ_DATA_WIDTH-1:0] q_data,
  input  logic                     iq_valid,
  input  logic                     short_preamble_detected,
  input  logic                     sig_valid,
  input  logic [LEN_WIDTH-1:0]     signal_len,
  input  logic                     demod_is_ongoing,
  input  logic [3:0]               cause_en,
  input  logic [7:0]               dc_running_sum_th,
  input  logic [LEN_WIDTH-1:0]     min_signal_len_th,
  input  logic [LEN_WIDTH-1:0]     max_signal_len_th,
  input  logic [TIMER_WIDTH-1:0]   header_timeout_th,
  input  logic [TIMER_WIDTH-1:0]   demod_timeout_th,
  output logic                     receiver_rst,
  output logic [3:0]               rst_cause,
  output logic [CNT_WIDTH-1:0]     cnt_dc,
  output logic [CNT_WIDTH-1:0]     cnt_len,
  output logic [CNT_WIDTH-1:0]     cnt_hdr,
  output logic [CNT_WIDTH-1:0]     cnt_demod
);

  localparam int WIN     = 1 << LOG2_DC_WIN;
  localparam int SUM_W   = LOG2_DC_WIN + 1;
  localparam int CMP_W   = ((SUM_W > 8) ? SUM_W : 8) + 1;
  localparam int PULSE_W = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN + 1) : 1;

  // Cause bit positions: {demod, hdr, len, dc}
  localparam logic [3:0] CAUSE_DC    = 4'b0001;
  localparam logic [3:0] CAUSE_LEN   = 4'b0010;
  localparam logic [3:0] CAUSE_HDR   = 4'b0100;
  localparam logic [3:0] CAUSE_DEMOD = 4'b1000;

  typedef enum logic [1:0] {IDLE, WAIT_HDR, DEMOD, RST} state_t;

  state_t                 state_reg, state_next;
  logic [3:0]             cause_next;
  logic                   rst_entry;
  logic                   preamble_d_reg, demod_d_reg;
  logic                   preamble_rise, demod_fall;
  logic [TIMER_WIDTH-1:0] timer_reg;
  logic [PULSE_W-1:0]     pulse_cnt_reg;
  logic                   receiver_rst_reg;
  logic [3:0]             rst_cause_reg;

  logic [WIN-1:0]         sr_i_reg, sr_q_reg;
  logic [SUM_W-1:0]       sum_i_reg, sum_q_reg;
  logic [SUM_W-1:0]       fill_reg;
  logic                   dc_full, dc_active, dc_clear;
  logic                   sign_i, sign_q;
  logic [CMP_W-1:0]       sum_i_ext, sum_q_ext, th_ext, win_ext;

  logic                   len_bad;
  logic                   len_fault, hdr_fault, dc_fault, demod_fault;

  // Only the sign of each component feeds the DC balance check.
  assign sign_i = i_data[IQ_DATA_WIDTH-1];
  assign sign_q = q_data[IQ_DATA_WIDTH-1];
  logic unused_iq_magnitude;
  assign unused_iq_magnitude = ^{i_data[IQ_DATA_WIDTH-2:0], q_data[IQ_DATA_WIDTH-2:0]};

  assign preamble_rise = short_preamble_detected & ~preamble_d_reg;
  assign demod_fall    = ~demod_is_ongoing & demod_d_reg;

  // Fault detection; the DC comparison adds th to the sum so WIN-th never goes negative.
  assign dc_full   = (fill_reg == SUM_W'(WIN));
  assign dc_active = (state_reg == IDLE) || (state_reg == WAIT_HDR);
  assign sum_i_ext = CMP_W'(sum_i_reg);
  assign sum_q_ext = CMP_W'(sum_q_reg);
  assign th_ext    = CMP_W'(dc_running_sum_th);
  assign win_ext   = CMP_W'(WIN);

  assign len_bad = ((min_signal_len_th != '0) && (signal_len < min_signal_len_th)) ||
                   ((max_signal_len_th != '0) && (signal_len > max_signal_len_th));

  assign len_fault   = (state_reg == WAIT_HDR) && sig_valid && len_bad && cause_en[1];
  assign hdr_fault   = (state_reg == WAIT_HDR) && (header_timeout_th != '0) &&
                       (timer_reg >= header_timeout_th) && cause_en[2];
  assign demod_fault = (state_reg == DEMOD) && (demod_timeout_th != '0) &&
                       (timer_reg >= demod_timeout_th) && cause_en[3];
  assign dc_fault    = dc_active && dc_full && (dc_running_sum_th != '0) && cause_en[0] &&
                       ((sum_i_ext <= th_ext) || ((sum_i_ext + th_ext) >= win_ext) ||
                        (sum_q_ext <= th_ext) || ((sum_q_ext + th_ext) >= win_ext));

  // Next-state and prioritised cause selection (len > hdr > dc; demod is exclusive to DEMOD).
  always_comb begin
    state_next = state_reg;
    cause_next = '0;
    if (len_fault)        cause_next = CAUSE_LEN;
    else if (hdr_fault)   cause_next = CAUSE_HDR;
    else if (dc_fault)    cause_next = CAUSE_DC;
    else if (demod_fault) cause_next = CAUSE_DEMOD;
    case (state_reg)
      IDLE: begin
        if (cause_next != '0)   state_next = RST;
        else if (preamble_rise) state_next = WAIT_HDR;
      end
      WAIT_HDR: begin
        if (cause_next != '0) state_next = RST;
        else if (sig_valid)   state_next = DEMOD;
      end
      DEMOD: begin
        if (cause_next != '0) state_next = RST;
        else if (demod_fall)  state_next = IDLE;
      end
      RST: begin
        cause_next = '0;
        if (pulse_cnt_reg == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (!enable) begin
      state_next = IDLE;
      cause_next = '0;
    end
  end

  assign rst_entry = (state_reg != RST) && (state_next == RST);
  assign dc_clear  = !enable || (state_reg == RST) || (state_next == RST);

  // State register, edge-detect history and reset pulse generation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg        <= IDLE;
      preamble_d_reg   <= 1'b0;
      demod_d_reg      <= 1'b0;
      pulse_cnt_reg    <= '0;
      receiver_rst_reg <= 1'b0;
      rst_cause_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      preamble_d_reg   <= short_preamble_detected;
      demod_d_reg      <= demod_is_ongoing;
      receiver_rst_reg <= (state_next == RST);
      if (rst_entry) begin
        pulse_cnt_reg <= PULSE_W'(RST_PULSE_LEN - 1);
        rst_cause_reg <= cause_next;
      end else if ((state_reg == RST) && (pulse_cnt_reg != '0)) begin
        pulse_cnt_reg <= pulse_cnt_reg - 1'b1;
      end
    end
  end

  // Header/demod timer: restarts on every state change, counts samples, saturates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timer_reg <= '0;
    end else if (state_next != state_reg) begin
      timer_reg <= '0;
    end else if (((state_reg == WAIT_HDR) || (state_reg == DEMOD)) && iq_valid &&
                 (timer_reg != {TIMER_WIDTH{1'b1}})) begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

  // Sliding window of sign bits with running counts of negative samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_i_reg  <= '0;
      sr_q_reg  <= '0;
      sum_i_reg <= '0;
      sum_q_reg <= '0;
      fill_reg  <= '0;
    end else if (dc_clear) begin
      sr_i_reg  <= '0;
      sr_q_reg  <= '0;
      sum_i_reg <= '0;
      sum_q_reg <= '0;
      fill_reg  <= '0;
    end else if (dc_active && iq_valid) begin
      sr_i_reg  <= {sr_i_reg[WIN-2:0], sign_i};
      sr_q_reg  <= {sr_q_reg[WIN-2:0], sign_q};
      sum_i_reg <= sum_i_reg + SUM_W'(sign_i) - SUM_W'(sr_i_reg[WIN-1]);
      sum_q_reg <= sum_q_reg + SUM_W'(sign_q) - SUM_W'(sr_q_reg[WIN-1]);
      if (!dc_full) fill_reg <= fill_reg + 1'b1;
    end
  end

  // Saturating per-cause event counters, one per cause bit.
  logic [CNT_WIDTH-1:0] cnt_all [4];
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;
      // Count each reset entry attributed to this cause.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          cnt_reg <= '0;
        end else if (rst_entry && cause_next[gi] && (cnt_reg != {CNT_WIDTH{1'b1}})) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign cnt_all[gi] = cnt_reg;
    end
  endgenerate

  assign receiver_rst = receiver_rst_reg;
  assign rst_cause    = rst_cause_reg;
  assign cnt_dc       = cnt_all[0];
  assign cnt_len      = cnt_all[1];
  assign cnt_hdr      = cnt_all[2];
  assign cnt_demod    = cnt_all[3];

endmodule
